// File: rtl/pulse_gen_pkg.sv
// Shared types and defaults for the test pulse generator.
package pulse_gen_pkg;

  // Train sequencer states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2
  } state_e;

  localparam int DEF_WIDTH_W = 8;
  localparam int DEF_GAP_W   = 16;
  localparam int DEF_CNT_W   = 16;

  // Larger of two widths; used to size the shared phase counter.
  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/test_pulse_generator_if.sv
// Bundle of the pulse generator control/status signals.
interface test_pulse_generator_if #(
  parameter int WIDTH_W = 8,
  parameter int GAP_W   = 16,
  parameter int CNT_W   = 16
) (
  input logic clk
);
  logic               start;
  logic               stop;
  logic [WIDTH_W-1:0] cfg_width;
  logic [GAP_W-1:0]   cfg_gap;
  logic [CNT_W-1:0]   cfg_count;
  logic               channel;
  logic               busy;
  logic               done;
  logic [CNT_W-1:0]   sent_count;

  // Controller side: issues requests and configuration, observes status.
  modport master (
    input  clk,
    output start, stop, cfg_width, cfg_gap, cfg_count,
    input  channel, busy, done, sent_count
  );

  // Generator side.
  modport slave (
    input  clk,
    input  start, stop, cfg_width, cfg_gap, cfg_count,
    output channel, busy, done, sent_count
  );
endinterface

// File: rtl/phase_counter.sv
// Reloadable down-counter timing the HIGH and LOW phases.
// zero_o is high while the loaded phase is in its final cycle.
module phase_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic         zero_o
);
  logic [W-1:0] count_q;

  // Load has priority; otherwise count down and park at zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else if (load_i) begin
      count_q <= load_val_i;
    end else if (count_q != '0) begin
      count_q <= count_q - W'(1);
    end
  end

  assign zero_o = (count_q == '0);
endmodule

// File: rtl/test_pulse_generator.sv
// Emulated detector pulse-train source: width/gap/count configurable,
// start/stop control, all outputs straight from flops.
module test_pulse_generator
  import pulse_gen_pkg::*;
#(
  parameter int WIDTH_W = DEF_WIDTH_W,
  parameter int GAP_W   = DEF_GAP_W,
  parameter int CNT_W   = DEF_CNT_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               stop,
  input  logic [WIDTH_W-1:0] cfg_width,
  input  logic [GAP_W-1:0]   cfg_gap,
  input  logic [CNT_W-1:0]   cfg_count,
  output logic               channel,
  output logic               busy,
  output logic               done,
  output logic [CNT_W-1:0]   sent_count
);
  localparam int PH_W = max_int(WIDTH_W, GAP_W);

  state_e             state_q;
  logic               channel_q;
  logic               busy_q;
  logic               done_q;
  logic [CNT_W-1:0]   sent_count_q;
  logic [WIDTH_W-1:0] width_q;
  logic [GAP_W-1:0]   gap_q;
  logic [CNT_W-1:0]   count_q;

  logic               ph_load_d;
  logic [PH_W-1:0]    ph_val_d;
  logic               ph_zero;
  logic [CNT_W-1:0]   sent_inc_d;
  logic               last_pulse_d;
  logic [PH_W-1:0]    start_width_ext;
  logic [PH_W-1:0]    width_ext;
  logic [PH_W-1:0]    gap_ext;

  // A phase of length L loads L-1; zero lengths are stretched to one cycle.
  assign start_width_ext = PH_W'(cfg_width);
  assign width_ext       = PH_W'(width_q);
  assign gap_ext         = PH_W'(gap_q);

  // A pulse finishing now is the last one when a nonzero count is reached.
  assign sent_inc_d   = sent_count_q + CNT_W'(1);
  assign last_pulse_d = (count_q != '0) && (sent_inc_d == count_q);

  // Decide when the phase counter reloads and with which phase length.
  always_comb begin
    ph_load_d = 1'b0;
    ph_val_d  = '0;
    case (state_q)
      ST_IDLE: begin
        if (start && !stop) begin
          ph_load_d = 1'b1;
          ph_val_d  = (start_width_ext == '0) ? '0 : start_width_ext - PH_W'(1);
        end
      end
      ST_HIGH: begin
        if (!stop && ph_zero && !last_pulse_d) begin
          ph_load_d = 1'b1;
          ph_val_d  = (gap_ext == '0) ? '0 : gap_ext - PH_W'(1);
        end
      end
      ST_LOW: begin
        if (!stop && ph_zero) begin
          ph_load_d = 1'b1;
          ph_val_d  = (width_ext == '0) ? '0 : width_ext - PH_W'(1);
        end
      end
      default: begin
        ph_load_d = 1'b0;
        ph_val_d  = '0;
      end
    endcase
  end

  phase_counter #(.W(PH_W)) u_phase (
    .clk        (clk),
    .rst        (rst),
    .load_i     (ph_load_d),
    .load_val_i (ph_val_d),
    .zero_o     (ph_zero)
  );

  // Train sequencer with registered channel/busy/done/sent_count.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      channel_q    <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      sent_count_q <= '0;
      width_q      <= '0;
      gap_q        <= '0;
      count_q      <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          // stop on the same cycle vetoes the start.
          if (start && !stop) begin
            width_q      <= cfg_width;
            gap_q        <= cfg_gap;
            count_q      <= cfg_count;
            sent_count_q <= '0;
            state_q      <= ST_HIGH;
            channel_q    <= 1'b1;
            busy_q       <= 1'b1;
          end
        end
        ST_HIGH: begin
          if (stop) begin
            // Aborted pulse is not counted.
            state_q   <= ST_IDLE;
            channel_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b1;
          end else if (ph_zero) begin
            sent_count_q <= sent_inc_d;
            channel_q    <= 1'b0;
            if (last_pulse_d) begin
              state_q <= ST_IDLE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              state_q <= ST_LOW;
            end
          end
        end
        ST_LOW: begin
          if (stop) begin
            state_q   <= ST_IDLE;
            channel_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b1;
          end else if (ph_zero) begin
            state_q   <= ST_HIGH;
            channel_q <= 1'b1;
          end
        end
        default: begin
          state_q   <= ST_IDLE;
          channel_q <= 1'b0;
          busy_q    <= 1'b0;
        end
      endcase
    end
  end

  assign channel    = channel_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign sent_count = sent_count_q;
endmodule

// File: tb/tb_test_pulse_generator.sv
// Self-checking bench for test_pulse_generator against a timing-formula model.
module tb_test_pulse_generator;
  localparam int WIDTH_W = 8;
  localparam int GAP_W   = 16;
  localparam int CNT_W   = 16;

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  test_pulse_generator_if #(.WIDTH_W(WIDTH_W), .GAP_W(GAP_W), .CNT_W(CNT_W)) bus (.clk(clk));

  test_pulse_generator #(.WIDTH_W(WIDTH_W), .GAP_W(GAP_W), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (bus.start),
    .stop       (bus.stop),
    .cfg_width  (bus.cfg_width),
    .cfg_gap    (bus.cfg_gap),
    .cfg_count  (bus.cfg_count),
    .channel    (bus.channel),
    .busy       (bus.busy),
    .done       (bus.done),
    .sent_count (bus.sent_count)
  );

  // ---------------- reference model ----------------
  // t = cycles after the cycle in which start was sampled (t=1: first high cycle).
  // W/P = effective high time / period; c = count; ts = stop cycle (0 = none).
  function automatic int m_tdone(int W, int P, int c);
    return (c == 0) ? 0 : (c - 1) * P + W + 1;
  endfunction

  function automatic bit m_active(int t, int W, int P, int c, int ts);
    int td = m_tdone(W, P, c);
    return (t >= 1) && (c == 0 || t < td) && (ts == 0 || t <= ts);
  endfunction

  function automatic bit m_channel(int t, int W, int P, int c, int ts);
    return m_active(t, W, P, c, ts) && (((t - 1) % P) < W);
  endfunction

  function automatic bit m_done(int t, int W, int P, int c, int ts);
    int td = m_tdone(W, P, c);
    return (c != 0 && t == td && (ts == 0 || ts >= td)) ||
           (ts != 0 && t == ts + 1 && m_active(ts, W, P, c, ts));
  endfunction

  function automatic int m_sent(int t, int W, int P, int c, int ts);
    int x = (ts != 0 && t > ts) ? ts : t;
    int n = (x > W) ? ((x - 1 - W) / P + 1) : 0;
    if (c != 0 && n > c) n = c;
    return n;
  endfunction

  // Start one train and compare every output on every cycle against the model.
  // noisy: scramble config and fire start while busy (both must be ignored).
  task automatic run_train(input string name, input int w, input int g, input int c,
                           input int ts, input int n, input bit noisy, output int dones);
    int W = (w == 0) ? 1 : w;
    int G = (g == 0) ? 1 : g;
    int P = W + G;
    int errs0 = errors;
    dones = 0;
    @(posedge clk); #1;
    bus.start = 1'b1; bus.stop = 1'b0;
    bus.cfg_width = WIDTH_W'(w); bus.cfg_gap = GAP_W'(g); bus.cfg_count = CNT_W'(c);
    for (int t = 1; t <= n; t++) begin
      @(posedge clk); #1;
      bus.start = 1'b0;
      bus.stop  = (ts != 0 && t == ts);
      if (noisy) begin
        bus.cfg_width = WIDTH_W'($urandom);
        bus.cfg_gap   = GAP_W'($urandom);
        bus.cfg_count = CNT_W'($urandom);
        if (m_active(t, W, P, c, ts)) bus.start = 1'($urandom_range(0, 1));
      end
      @(negedge clk);
      checks += 4;
      if (bus.channel !== m_channel(t, W, P, c, ts)) begin
        errors++;
        $display("FAIL %s channel t=%0d got=%b exp=%b", name, t, bus.channel, m_channel(t, W, P, c, ts));
      end
      if (bus.busy !== m_active(t, W, P, c, ts)) begin
        errors++;
        $display("FAIL %s busy t=%0d got=%b exp=%b", name, t, bus.busy, m_active(t, W, P, c, ts));
      end
      if (bus.done !== m_done(t, W, P, c, ts)) begin
        errors++;
        $display("FAIL %s done t=%0d got=%b exp=%b", name, t, bus.done, m_done(t, W, P, c, ts));
      end
      if (bus.sent_count !== CNT_W'(m_sent(t, W, P, c, ts))) begin
        errors++;
        $display("FAIL %s sent_count t=%0d got=%0d exp=%0d", name, t, bus.sent_count, m_sent(t, W, P, c, ts));
      end
      if (bus.done === 1'b1) dones++;
    end
    @(posedge clk); #1;
    bus.start = 1'b0; bus.stop = 1'b0;
    $display("train %s w=%0d g=%0d c=%0d stop_t=%0d sent=%0d dones=%0d errs=%0d",
             name, w, g, c, ts, bus.sent_count, dones, errors - errs0);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1;
    bus.start = 1'b1; bus.stop = 1'b0;
    bus.cfg_width = 8'd4; bus.cfg_gap = 16'd4; bus.cfg_count = 16'd2;
    repeat (3) @(posedge clk);
    #1; bus.start = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus.channel, bus.busy, bus.done, bus.sent_count} !== {3'b000, 16'd0}) begin
      errors++;
      $display("FAIL reset ch/busy/done/sent got=%b%b%b/%0d exp=000/0",
               bus.channel, bus.busy, bus.done, bus.sent_count);
    end
    @(posedge clk); #1; rst = 1'b0;
    $display("reset released");
  endtask

  task automatic test_start_stop_idle();
    @(posedge clk); #1;
    bus.stop = 1'b1;                       // stop alone in IDLE
    bus.cfg_width = 8'd3; bus.cfg_gap = 16'd3; bus.cfg_count = 16'd1;
    @(posedge clk); #1;
    bus.start = 1'b1; bus.stop = 1'b1;     // both together: stop wins
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      bus.start = 1'b0; bus.stop = 1'b0;
      @(negedge clk);
      checks++;
      if ({bus.channel, bus.busy, bus.done, bus.sent_count} !== {3'b000, 16'd0}) begin
        errors++;
        $display("FAIL start_stop_idle cyc=%0d ch/busy/done/sent got=%b%b%b/%0d exp=000/0",
                 i, bus.channel, bus.busy, bus.done, bus.sent_count);
      end
    end
    $display("start+stop in idle: busy=%b", bus.busy);
  endtask

  task automatic test_basic();
    int dn;
    run_train("basic", 3, 5, 4, 0, 32, 1'b0, dn);
    checks += 2;
    if (dn !== 1) begin
      errors++;
      $display("FAIL basic done_pulses got=%0d exp=1", dn);
    end
    if (bus.sent_count !== 16'd4) begin
      errors++;
      $display("FAIL basic final_sent got=%0d exp=4", bus.sent_count);
    end
  endtask

  task automatic test_min_width();
    int dn;
    run_train("min", 0, 0, 3, 0, 10, 1'b0, dn);
    checks++;
    if (dn !== 1) begin
      errors++;
      $display("FAIL min done_pulses got=%0d exp=1", dn);
    end
  endtask

  task automatic test_continuous_stop();
    int dn;
    run_train("continuous", 2, 2, 0, 20, 26, 1'b1, dn);
    checks += 2;
    if (dn !== 1) begin
      errors++;
      $display("FAIL continuous done_pulses got=%0d exp=1", dn);
    end
    if (bus.sent_count !== 16'd5) begin
      errors++;
      $display("FAIL continuous final_sent got=%0d exp=5", bus.sent_count);
    end
  endtask

  task automatic test_rst_mid();
    int dn;
    @(posedge clk); #1;
    bus.start = 1'b1; bus.cfg_width = 8'd10; bus.cfg_gap = 16'd3; bus.cfg_count = 16'd2;
    repeat (4) begin
      @(posedge clk); #1;
      bus.start = 1'b0;
    end
    checks++;
    if (bus.channel !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid pre_channel got=%b exp=1", bus.channel);
    end
    rst = 1'b1; bus.start = 1'b1; bus.stop = 1'b1;   // reset overrides both
    @(posedge clk); #1;
    rst = 1'b0; bus.start = 1'b0; bus.stop = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if ({bus.channel, bus.busy, bus.done, bus.sent_count} !== {3'b000, 16'd0}) begin
        errors++;
        $display("FAIL rst_mid cyc=%0d ch/busy/done/sent got=%b%b%b/%0d exp=000/0",
                 i, bus.channel, bus.busy, bus.done, bus.sent_count);
      end
      @(posedge clk); #1;
    end
    $display("reset mid-train handled");
    run_train("after_rst", 1, 1, 1, 0, 5, 1'b0, dn);
  endtask

  task automatic test_loopback();
    int  edges = 0;
    int  dn = 0;
    int  cyc = 0;
    bit  prev = 1'b0;
    @(posedge clk); #1;
    bus.start = 1'b1; bus.cfg_width = 8'd20; bus.cfg_gap = 16'd500; bus.cfg_count = 16'd2;
    @(posedge clk); #1;
    bus.start = 1'b0;
    while (dn == 0 && cyc < 2000) begin
      @(negedge clk);
      if (bus.channel === 1'b1 && prev == 1'b0) edges++;
      prev = bus.channel;
      if (bus.done === 1'b1) dn++;
      cyc++;
    end
    checks += 2;
    if (dn == 0) begin
      errors++;
      $display("FAIL loopback timeout cycles=%0d exp done within 2000", cyc);
    end
    if (edges !== 2) begin
      errors++;
      $display("FAIL loopback shaper_pulses got=%0d exp=2", edges);
    end
    $display("loopback pulses=%0d cycles=%0d", edges, cyc);
    repeat (2) @(posedge clk);
  endtask

  task automatic test_random();
    int dn;
    for (int k = 0; k < 14; k++) begin
      int w  = $urandom_range(0, 6);
      int g  = $urandom_range(0, 6);
      int c  = $urandom_range(0, 5);
      int W  = (w == 0) ? 1 : w;
      int G  = (g == 0) ? 1 : g;
      int td = m_tdone(W, W + G, c);
      int ts = 0;
      int n;
      if (c == 0 || $urandom_range(0, 1) == 1)
        ts = $urandom_range(1, (c == 0) ? 40 : td + 2);
      n = ((ts != 0 && (c == 0 || ts < td)) ? ts : td) + 3;
      run_train($sformatf("rand%0d", k), w, g, c, ts, n, 1'b1, dn);
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.start = 1'b0; bus.stop = 1'b0;
    bus.cfg_width = '0; bus.cfg_gap = '0; bus.cfg_count = '0;
    test_reset();
    test_start_stop_idle();
    test_basic();
    test_min_width();
    test_continuous_stop();
    test_rst_mid();
    test_loopback();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/test_pulse_generator.md
TEST_PULSE_GENERATOR -- requirements
Module: test_pulse_generator

Interface
REQ-001 SHALL have parameter WIDTH_W, default 8, bit width of the high-time configuration.
REQ-002 SHALL have parameter GAP_W, default 16, bit width of the low-time configuration.
REQ-003 SHALL have parameter CNT_W, default 16, bit width of the pulse-count configuration and counter.
REQ-004 SHALL have port clk  input  1  sole clock; all logic on its rising edge.
REQ-005 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-006 SHALL have port start  input  1  one-cycle request to begin a pulse train.
REQ-007 SHALL have port stop  input  1  one-cycle request to abort the current train.
REQ-008 SHALL have port cfg_width  input  WIDTH_W  high time in clk cycles.
REQ-009 SHALL have port cfg_gap  input  GAP_W  low time between pulses in clk cycles.
REQ-010 SHALL have port cfg_count  input  CNT_W  number of pulses; 0 means continuous.
REQ-011 SHALL have port channel  output  1  emulated detector line, registered, for driving the pulse shaper input.
REQ-012 SHALL have port busy  output  1  high while a train is active.
REQ-013 SHALL have port done  output  1  one-cycle strobe when a train ends (normally or by stop).
REQ-014 SHALL have port sent_count  output  CNT_W  pulses completed in the current or last train.

Function
REQ-015 SHALL implement states IDLE, HIGH, LOW.
REQ-016 IDLE: start=1 and stop=0 SHALL latch cfg_* , clear sent_count, enter HIGH; channel=1 from the next cycle.
REQ-017 HIGH SHALL hold channel=1 for exactly max(cfg_width,1) cycles, then increment sent_count (wrapping modulo 2^CNT_W).
REQ-018 After HIGH: if latched count nonzero and incremented sent_count equals it, SHALL enter IDLE and pulse done; else enter LOW.
REQ-019 LOW SHALL hold channel=0 for exactly max(cfg_gap,1) cycles, then enter HIGH; consecutive pulses are never merged.
REQ-020 Config inputs SHALL be ignored outside the start-acceptance cycle; changes mid-train have no effect.
REQ-021 start while busy SHALL be ignored.
REQ-022 stop in HIGH or LOW SHALL force channel=0 and busy=0 the next cycle, enter IDLE, pulse done; sent_count keeps completed pulses only.
REQ-023 start and stop together in IDLE: stop SHALL win; no train starts, done stays 0.
REQ-024 stop in IDLE SHALL have no effect.
REQ-025 busy SHALL equal (state != IDLE); done SHALL never assert for two consecutive cycles.
REQ-026 Continuous mode (count=0) SHALL run until stop or rst.

Reset
REQ-027 rst SHALL force state=IDLE, channel=0, busy=0, done=0, sent_count=0, latched config=0 on the next edge, overriding start/stop.
REQ-028 rst mid-train SHALL end the train without a done strobe.

Structure
REQ-029 State encoding and default widths SHALL live in shared package pulse_gen_pkg.
REQ-030 HIGH/LOW timing SHALL use one reloadable down-counter sub-module, phase_counter, sized max(WIDTH_W,GAP_W).
REQ-031 All outputs SHALL be driven directly from flops.

Verification
REQ-032 width=3, gap=5, count=4, start at cycle 10 -> channel high cycles 11-13, 19-21, 27-29, 35-37; done at cycle 37-38 boundary once; sent_count=4.
REQ-033 width=0, gap=0, count=3 -> three 1-cycle pulses separated by 1 low cycle; done once.
REQ-034 count=0, width=2, gap=2, stop after 20 cycles -> channel low next cycle, done one cycle, sent_count equals completed pulses (5).
REQ-035 start and stop same cycle in IDLE -> busy stays 0, channel stays 0, done stays 0.
REQ-036 rst asserted during HIGH of a width=10 train -> next cycle channel=0, busy=0, sent_count=0, no done; new start accepted afterwards.
REQ-037 Loopback into the pulse shaper with width=20, gap=500, count=2 -> exactly two shaper output pulses.
